// File: rtl/uart_rx_engine_if.sv
// Processor read port of the UART receive engine: address/strobe toward the engine,
// received byte and status flags back to the processor.
interface uart_rx_engine_if;
  logic [15:0] port_id;
  logic        read_strobe;
  logic [7:0]  in_port;
  logic        rx_rdy;
  logic        perr;
  logic        ferr;
  logic        ovf;
  logic        brk;

  modport master (
    output port_id, read_strobe,
    input  in_port, rx_rdy, perr, ferr, ovf, brk
  );

  modport slave (
    input  port_id, read_strobe,
    output in_port, rx_rdy, perr, ferr, ovf, brk
  );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizes rx, frames 7/8 data bits (+optional parity), and holds
// the byte and status for the processor. Define UART_RX_BREAK_EN to enable break detect.
module uart_rx_engine (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic [3:0]      baud_in,
  input  logic            Eight,
  input  logic            Pen,
  input  logic            OHEL,
  uart_rx_engine_if.slave bus
);

  localparam int unsigned CNT_W  = 19;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned SHR_W  = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BAUD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               rx_meta_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [SHR_W-1:0]   bits_q, bits_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic               eight_q, eight_d;
  logic               pen_q, pen_d;
  logic               ohel_q, ohel_d;
  logic               done_q, done_d;
  logic               stop_q, stop_d;

  logic [DATA_W-1:0]  data_q, data_d;
  logic               rx_rdy_q, rx_rdy_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               ovf_q, ovf_d;

  logic [CNT_W-1:0]   full_m1;
  logic [CNT_W-1:0]   half_m1;
  logic [BIT_W-1:0]   last_idx;
  logic [DATA_W-1:0]  frame_data;
  logic               frame_par;
  logic               frame_perr;
  logic               read_clr;
  logic               take_frame;

  // Bit-time in clocks for each baud select; out-of-range selects use the fastest rate
  function automatic logic [CNT_W-1:0] bit_time(input logic [BAUD_W-1:0] sel);
    case (sel)
      4'd0:    bit_time = 19'd333333;
      4'd1:    bit_time = 19'd83333;
      4'd2:    bit_time = 19'd41667;
      4'd3:    bit_time = 19'd20833;
      4'd4:    bit_time = 19'd10417;
      4'd5:    bit_time = 19'd5208;
      4'd6:    bit_time = 19'd2604;
      4'd7:    bit_time = 19'd1736;
      4'd8:    bit_time = 19'd868;
      4'd9:    bit_time = 19'd434;
      4'd10:   bit_time = 19'd217;
      default: bit_time = 19'd109;
    endcase
  endfunction

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign full_m1  = bit_time(baud_q) - CNT_W'(1);
  assign half_m1  = (bit_time(baud_q) >> 1) - CNT_W'(1);
  assign last_idx = (eight_q ? BIT_W'(7) : BIT_W'(6)) + BIT_W'(pen_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      bits_q    <= '0;
      baud_q    <= '0;
      eight_q   <= 1'b0;
      pen_q     <= 1'b0;
      ohel_q    <= 1'b0;
      done_q    <= 1'b0;
      stop_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      bits_q    <= bits_d;
      baud_q    <= baud_d;
      eight_q   <= eight_d;
      pen_q     <= pen_d;
      ohel_q    <= ohel_d;
      done_q    <= done_d;
      stop_q    <= stop_d;
    end
  end

  // Frame sequencer; frame format is captured at the start edge and held to the stop bit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    bits_d    = bits_q;
    baud_d    = baud_q;
    eight_d   = eight_q;
    pen_d     = pen_q;
    ohel_d    = ohel_q;
    done_d    = 1'b0;
    stop_d    = stop_q;

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d   = START;
          cnt_d     = '0;
          bit_idx_d = '0;
          bits_d    = '0;
          baud_d    = baud_in;
          eight_d   = Eight;
          pen_d     = Pen;
          ohel_d    = OHEL;
        end
      end

      START: begin
        if (cnt_q == half_m1) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == full_m1) begin
          cnt_d  = '0;
          bits_d = bits_q | (SHR_W'(rx_s_q) << bit_idx_q);
          if (bit_idx_q == last_idx) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == full_m1) begin
          cnt_d   = '0;
          stop_d  = rx_s_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Received-frame view; in 7-bit mode the parity bit sits at index 7 and must not leak into data
  assign frame_data = eight_q ? bits_q[7:0] : {1'b0, bits_q[6:0]};
  assign frame_par  = eight_q ? bits_q[8] : bits_q[7];
  assign frame_perr = pen_q & ((^frame_data ^ frame_par) != ohel_q);

  assign read_clr   = (bus.port_id == 16'h0000) && bus.read_strobe;
  // A completing frame is stored unless it would overwrite an unread byte
  assign take_frame = done_q && (!rx_rdy_q || read_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      rx_rdy_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      rx_rdy_q <= rx_rdy_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    data_d   = data_q;
    rx_rdy_d = rx_rdy_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ovf_d    = ovf_q;

    if (take_frame) begin
      data_d   = frame_data;
      rx_rdy_d = 1'b1;
      perr_d   = frame_perr;
      ferr_d   = !stop_q;
      ovf_d    = 1'b0;
    end else if (done_q) begin
      ovf_d = 1'b1;
    end else if (read_clr) begin
      rx_rdy_d = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      ovf_d    = 1'b0;
    end
  end

`ifdef UART_RX_BREAK_EN
  logic brk_q, brk_d;
  logic frame_brk;

  // Break: every sampled bit of the frame, stop included, was low
  assign frame_brk = (frame_data == '0) && (!pen_q || !frame_par) && !stop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk_q <= 1'b0;
    end else begin
      brk_q <= brk_d;
    end
  end

  always_comb begin
    brk_d = brk_q;
    if (take_frame) begin
      brk_d = frame_brk;
    end else if (!done_q && read_clr) begin
      brk_d = 1'b0;
    end
  end

  assign bus.brk = brk_q;
`else
  assign bus.brk = 1'b0;
`endif

  assign bus.in_port = data_q;
  assign bus.rx_rdy  = rx_rdy_q;
  assign bus.perr    = perr_q;
  assign bus.ferr    = ferr_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: directed frames push expected results,
// an independent monitor compares whenever the engine presents a new result.
`timescale 1ns/1ps
module tb_uart_rx_engine;

  localparam int unsigned FAST_CNT = 109;
  localparam int unsigned SLOW_CNT = 868;

`ifdef UART_RX_BREAK_EN
  localparam logic BRK_ON = 1'b1;
`else
  localparam logic BRK_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       rdy;
    logic       perr;
    logic       ferr;
    logic       ovf;
    logic       brk;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [3:0] baud_in;
  logic       Eight;
  logic       Pen;
  logic       OHEL;

  uart_rx_engine_if bus();

  uart_rx_engine dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .baud_in (baud_in),
    .Eight   (Eight),
    .Pen     (Pen),
    .OHEL    (OHEL),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat_fast = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic [7:0] d, input logic pe, input logic fe,
                              input logic ov, input logic bk);
    obs_t o;
    o = {d, 1'b1, pe, fe, ov, bk};
    return o;
  endfunction

  function automatic logic [4:0] flags();
    return {bus.rx_rdy, bus.perr, bus.ferr, bus.ovf, bus.brk};
  endfunction

  // Monitor: a new result is a rising rx_rdy, a rising ovf, or fresh data while ready
  obs_t prev_obs;
  always @(negedge clk) begin
    obs_t cur;
    obs_t exp;
    cur = {bus.in_port, bus.rx_rdy, bus.perr, bus.ferr, bus.ovf, bus.brk};
    if (reset === 1'b1) begin
      if ((cur.rdy && !prev_obs.rdy) || (cur.ovf && !prev_obs.ovf) ||
          (cur.rdy && cur.data != prev_obs.data)) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, expected no output", cur);
        end else begin
          exp = sb.pop_front();
          check("frame_result", 32'(cur), 32'(exp));
        end
      end
    end
    prev_obs = cur;
  end

  // Drive one frame starting at the next negedge: start, nbits LSB-first, stop, then idle high
  task automatic send(input logic [8:0] bits, input int nbits, input logic stop_bit, input int cnt);
    @(negedge clk);
    rx = 1'b0;
    repeat (cnt) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (cnt) @(negedge clk);
    end
    rx = stop_bit;
    repeat (cnt) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] pid);
    @(negedge clk);
    bus.port_id     = pid;
    bus.read_strobe = 1'b1;
    @(negedge clk);
    bus.read_strobe = 1'b0;
    bus.port_id     = 16'hFFFF;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  // Clocks from the frame's first negedge until rx_rdy is seen high
  task automatic measure(output int lat);
    int k;
    @(negedge clk);
    k = 0;
    while (!bus.rx_rdy && k < 12000) begin
      @(negedge clk);
      k++;
    end
    lat = k;
  endtask

  task automatic read_and_check(input string name);
    do_read(16'h0000);
    check(name, 32'(flags()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, expected finish before 900us");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    reset           = 1'b0;
    rx              = 1'b1;
    baud_in         = 4'd11;
    Eight           = 1'b1;
    Pen             = 1'b0;
    OHEL            = 1'b0;
    bus.port_id     = 16'hFFFF;
    bus.read_strobe = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_in_port", 32'(bus.in_port), 32'h00);
    check("rst_rx_rdy",  32'(bus.rx_rdy),  32'd0);
    check("rst_perr",    32'(bus.perr),    32'd0);
    check("rst_ferr",    32'(bus.ferr),    32'd0);
    check("rst_ovf",     32'(bus.ovf),     32'd0);
    check("rst_brk",     32'(bus.brk),     32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 at 115200 (868 clocks/bit)
    baud_in = 4'd8;
    sb.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    fork
      send(9'h0A5, 8, 1'b1, SLOW_CNT);
      measure(lat);
    join
    wait_drain("a5_8n1");
    check("a5_latency_window", 32'((lat >= 9 * SLOW_CNT) && (lat <= 10 * SLOW_CNT)), 32'd1);
    do_read(16'h0001);
    check("read_wrong_port", 32'(flags()), 32'b10000);
    read_and_check("a5_read_clear");

    // 7-bit odd parity, wrong parity bit
    baud_in = 4'd11;
    Eight = 1'b0; Pen = 1'b1; OHEL = 1'b1;
    sb.push_back(mk(8'h41, 1'b1, 1'b0, 1'b0, 1'b0));
    send(9'h041, 8, 1'b1, FAST_CNT);
    wait_drain("p41_bad_parity");
    read_and_check("p41_read_clear");

    // 7-bit even parity with parity bit 1: bit 7 of in_port must stay 0
    Eight = 1'b0; Pen = 1'b1; OHEL = 1'b0;
    sb.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0, 1'b0));
    send(9'h087, 8, 1'b1, FAST_CNT);
    wait_drain("p07_good_parity");
    read_and_check("p07_read_clear");

    // 8-bit even parity, correct
    Eight = 1'b1; Pen = 1'b1; OHEL = 1'b0;
    sb.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
    send(9'h03C, 9, 1'b1, FAST_CNT);
    wait_drain("p3c_good_parity");
    read_and_check("p3c_read_clear");

    // Framing error; format inputs change mid-frame and must be ignored
    Eight = 1'b1; Pen = 1'b0;
    sb.push_back(mk(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0));
    fork
      send(9'h05A, 8, 1'b0, FAST_CNT);
      begin
        repeat (300) @(negedge clk);
        Eight = 1'b0; Pen = 1'b1; baud_in = 4'd8;
      end
    join
    Eight = 1'b1; Pen = 1'b0; baud_in = 4'd11;
    wait_drain("f5a_ferr");
    read_and_check("f5a_read_clear");

    // All-zero frame with low stop bit: framing error and, if enabled, break
    sb.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0, BRK_ON));
    send(9'h000, 8, 1'b0, FAST_CNT);
    repeat (20) @(negedge clk);
    wait_drain("brk_frame");
    read_and_check("brk_read_clear");

    // Back-to-back frames without a read: first byte kept, overrun flagged
    sb.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(8'h11, 1'b0, 1'b0, 1'b1, 1'b0));
    fork
      begin
        send(9'h011, 8, 1'b1, FAST_CNT);
        send(9'h022, 8, 1'b1, FAST_CNT);
      end
      measure(lat_fast);
    join
    wait_drain("ovf_pair");
    check("ovf_in_port", 32'(bus.in_port), 32'h11);
    read_and_check("ovf_read_clear");

    // Read strobe lands in the completion clock of the second frame: new frame wins
    sb.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(8'h22, 1'b0, 1'b0, 1'b0, 1'b0));
    send(9'h011, 8, 1'b1, FAST_CNT);
    fork
      send(9'h022, 8, 1'b1, FAST_CNT);
      begin
        @(negedge clk);
        repeat (lat_fast - 1) @(negedge clk);
        bus.port_id     = 16'h0000;
        bus.read_strobe = 1'b1;
        @(negedge clk);
        bus.read_strobe = 1'b0;
        bus.port_id     = 16'hFFFF;
      end
    join
    wait_drain("race_pair");
    check("race_flags", 32'(flags()), 32'b10000);
    read_and_check("race_read_clear");

    // Start glitch shorter than half a bit: rejected, then a clean frame
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_no_rdy", 32'(flags()), 32'd0);
    sb.push_back(mk(8'h66, 1'b0, 1'b0, 1'b0, 1'b0));
    send(9'h066, 8, 1'b1, FAST_CNT);
    wait_drain("after_glitch");
    read_and_check("after_glitch_clear");

    // Reset during the data bits aborts the frame
    @(negedge clk);
    rx = 1'b0;
    repeat (FAST_CNT) @(negedge clk);
    rx = 1'b1;
    repeat (FAST_CNT) @(negedge clk);
    rx = 1'b0;
    repeat (FAST_CNT + 50) @(negedge clk);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_in_port", 32'(bus.in_port), 32'h00);
    reset = 1'b1;
    repeat (1200) @(negedge clk);
    check("midrst_no_update", 32'({bus.in_port, flags()}), 32'd0);
    sb.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0));
    send(9'h0C3, 8, 1'b1, FAST_CNT);
    wait_drain("after_reset");

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 SHALL have port: clk  input  1  system clock, 100 MHz, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-003 SHALL have port: rx  input  1  asynchronous serial line, idle high.
REQ-004 SHALL have port: baud_in  input  4  baud select, same encoding as the transmit engine.
REQ-005 SHALL have port: Eight  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-006 SHALL have port: Pen  input  1  1 = parity bit present.
REQ-007 SHALL have port: OHEL  input  1  1 = odd parity, 0 = even parity.
REQ-008 SHALL have port: port_id  input  16  processor port address.
REQ-009 SHALL have port: read_strobe  input  1  processor read qualifier.
REQ-010 SHALL have port: in_port  output  8  last received data byte.
REQ-011 SHALL have ports: rx_rdy, perr, ferr, ovf  output  1 each  data ready, parity error, framing error, overrun.
REQ-012 SHALL have port: brk  output  1  break detected (see Configuration).

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all logic uses the synchronized rx_s.
REQ-014 SHALL map baud_in 0..11 to bit-time counts 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109; values 12..15 SHALL use 109. Counter width is 19 bits.
REQ-015 SHALL implement FSM IDLE, START, DATA, STOP.
REQ-016 IDLE: falling edge of rx_s -> START, bit-time counter cleared.
REQ-017 START: after count/2 clocks, sample rx_s; 0 -> DATA; 1 -> IDLE (glitch rejected, no flags change).
REQ-018 DATA: sample rx_s every full count, LSB first; 7 or 8 data bits per Eight, then one parity bit if Pen=1.
REQ-019 STOP: sample one full count later; rx_s=0 sets ferr. FSM returns to IDLE in the same clock.
REQ-020 Eight, Pen, OHEL, baud_in SHALL be latched on entry to START and held for the frame.
REQ-021 Parity check: perr=1 when Pen=1 and XOR(data bits, parity bit) != OHEL.
REQ-022 One clock after the stop sample, the data register SHALL load (bit 7 = 0 in 7-bit mode), rx_rdy=1, and perr/ferr update.
REQ-023 Read: port_id==0 and read_strobe SHALL clear rx_rdy, perr, ferr, ovf on the next clock.
REQ-024 Overrun: frame completes while rx_rdy=1 and no read in that clock -> ovf=1; the data register SHALL NOT be overwritten.
REQ-025 Read and frame completion in the same clock: completion wins; data loads, rx_rdy stays 1, flags take the new frame's values, ovf=0.
REQ-026 in_port SHALL drive the data register continuously, independent of port_id.
REQ-027 A new start edge SHALL be accepted in the first IDLE clock after STOP, giving back-to-back frames.

Reset
REQ-028 reset low SHALL force FSM=IDLE, counters=0, synchronizer=1, data register=0x00, rx_rdy=0, perr=0, ferr=0, ovf=0, brk=0.
REQ-029 Reset mid-frame SHALL abort the frame with no flag or data update after release.

Configuration
REQ-030 Macro UART_RX_BREAK_EN defined: brk=1 when a frame completes with all data bits 0, parity (if present) 0, and stop 0; brk clears with the read of REQ-023.
REQ-031 Macro UART_RX_BREAK_EN undefined: brk is constant 0, with no break logic synthesized.

Verification
REQ-032 baud_in=8, Eight=1, Pen=0, frame 0xA5 -> rx_rdy=1 about 10x868 clocks after the start edge, in_port=0xA5, all flags 0.
REQ-033 Eight=0, Pen=1, OHEL=1, data 0x41 with bad parity bit -> in_port=0x41, perr=1; read at port_id=0 -> all flags 0 next clock.
REQ-034 Frame with stop bit 0 -> ferr=1; with UART_RX_BREAK_EN defined, all-zero frame -> brk=1.
REQ-035 Two frames 0x11, 0x22 with no read -> in_port=0x11, ovf=1; read strobe in the completion clock of the second frame -> in_port=0x22, ovf=0.
REQ-036 rx low pulse shorter than count/2 -> no rx_rdy; reset low mid-DATA -> FSM IDLE, rx_rdy=0, next clean frame received correctly.
